// File: rtl/rope_if.sv
// rope_if: press-latch handshake and display bus between the upstream latches and rope_ctrl
//   push, tie, right : press status from the upstream latches (asynchronous to clk)
//   clear            : re-arm for the upstream latches
//   leds             : one-hot rope position, bit 0 = left end
//   win_l, win_r     : winner flags
//   moves            : saturating count of non-tie moves
interface rope_if;
   logic       push;
   logic       tie;
   logic       right;
   logic       clear;
   logic [8:0] leds;
   logic       win_l;
   logic       win_r;
   logic [7:0] moves;
   modport master(output push, tie, right, input clear, leds, win_l, win_r, moves);
   modport slave(input push, tie, right, output clear, leds, win_l, win_r, moves);
endinterface

// File: rtl/rope_ctrl.sv
// rope_ctrl: tug-of-war rope controller moving a one-hot LED position on each decided press
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : rope_if slave (push/tie/right in; clear/leds/win_l/win_r/moves out, all registered)
//   LOCKOUT : cycles clear is held after each decided push (3..255)
//   BLINK   : half-period in cycles of the winner LED blink (1..255)
module rope_ctrl #(
   parameter int LOCKOUT = 4,
   parameter int BLINK   = 8
) (
   input logic   clk,
   input logic   rst,
   rope_if.slave bus
);
   typedef enum logic [2:0] {IDLE, SETTLE, MOVE, LOCK, WIN} state_t;
   state_t     st;
   logic [2:0] s1, s2;
   logic       cap_tie, cap_right;
   logic [3:0] pos, np;
   logic [7:0] lcnt, bcnt;
   logic       push_s, tie_s, right_s;
   assign {push_s, tie_s, right_s} = s2;
   // tie wins over right when both were captured
   assign np = cap_tie ? pos : cap_right ? pos + 4'd1 : pos - 4'd1;
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         s1        <= '0;
         s2        <= '0;
         cap_tie   <= 1'b0;
         cap_right <= 1'b0;
         pos       <= 4'd4;
         lcnt      <= '0;
         bcnt      <= '0;
         bus.clear <= 1'b0;
         bus.leds  <= 9'b000010000;
         bus.win_l <= 1'b0;
         bus.win_r <= 1'b0;
         bus.moves <= '0;
      end else begin
         s1 <= {bus.push, bus.tie, bus.right};
         s2 <= s1;
         case (st)
            IDLE: if (push_s) st <= SETTLE;
            SETTLE: begin
               st        <= push_s ? MOVE : IDLE;
               cap_tie   <= tie_s;
               cap_right <= right_s;
            end
            MOVE: begin
               pos       <= np;
               bus.leds  <= 9'd1 << np;
               bus.clear <= 1'b1;
               bus.win_l <= np == 4'd0;
               bus.win_r <= np == 4'd8;
               lcnt      <= '0;
               bcnt      <= '0;
               if (!cap_tie && bus.moves != 8'd255) bus.moves <= bus.moves + 8'd1;
               st <= (np == 4'd0 || np == 4'd8) ? WIN : LOCK;
            end
            LOCK: begin
               if (lcnt == 8'(LOCKOUT - 1)) begin
                  st        <= IDLE;
                  bus.clear <= 1'b0;
               end else lcnt <= lcnt + 8'd1;
            end
            WIN: begin
               if (bcnt == 8'(BLINK - 1)) begin
                  bcnt     <= '0;
                  bus.leds <= bus.leds == '0 ? 9'd1 << pos : '0;
               end else bcnt <= bcnt + 8'd1;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rope_ctrl.sv
// tb_rope_ctrl: randomized self-checking bench for rope_ctrl against a press-level rope model
module tb_rope_ctrl;
   localparam int LOCKOUT = 4;
   localparam int BLINK   = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   ref_pos = 4;
   int   ref_moves = 0;
   bit   ref_won = 1'b0;
   rope_if bus();
   rope_ctrl #(.LOCKOUT(LOCKOUT), .BLINK(BLINK)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      ref_pos   = 4;
      ref_moves = 0;
      ref_won   = 1'b0;
      check("rst_leds", bus.leds, 32'h10);
      check("rst_moves", bus.moves, 0);
      check("rst_clear", bus.clear, 0);
      check("rst_win", {bus.win_l, bus.win_r}, 0);
   endtask

   task automatic press(input logic r, input logic t);
      int n;
      int len;
      bus.push  = 1'b1;
      bus.tie   = t;
      bus.right = r;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.clear && n < 20);
      check("latency", n, 5);
      bus.push  = 1'b0;
      bus.tie   = 1'b0;
      bus.right = 1'b0;
      if (!t) begin
         ref_pos   += r ? 1 : -1;
         ref_moves  = ref_moves < 255 ? ref_moves + 1 : 255;
      end
      ref_won = ref_pos == 0 || ref_pos == 8;
      check("leds", bus.leds, 32'd1 << ref_pos);
      check("moves", bus.moves, ref_moves);
      check("win", {bus.win_l, bus.win_r}, {ref_pos == 0, ref_pos == 8});
      if (ref_won) begin
         for (int k = 1; k < 3 * BLINK; k++) begin
            step();
            check("blink", bus.leds, ((k / BLINK) % 2 == 0) ? 32'd1 << ref_pos : 0);
            check("win_clear", bus.clear, 1);
         end
      end else begin
         len = 0;
         do begin
            step();
            len++;
         end while (bus.clear && len < 300);
         check("clear_len", len, LOCKOUT);
      end
   endtask

   task automatic glitch();
      logic [8:0] l0;
      logic [7:0] m0;
      int hi;
      l0 = bus.leds;
      m0 = bus.moves;
      hi = 0;
      bus.push  = 1'b1;
      bus.right = 1'($urandom_range(0, 1));
      step();
      bus.push  = 1'b0;
      bus.right = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.clear) hi++;
      end
      check("glitch_clear", hi, 0);
      check("glitch_leds", bus.leds, l0);
      check("glitch_moves", bus.moves, m0);
   endtask

   initial begin
      bus.push  = 1'b0;
      bus.tie   = 1'b0;
      bus.right = 1'b0;
      step();
      do_reset();
      press(1'b1, 1'b0);
      check("single_leds", bus.leds, 32'h20);
      press(1'b0, 1'b1);
      press(1'b1, 1'b1);
      check("tie_leds", bus.leds, 32'h20);
      check("tie_moves", bus.moves, 1);
      glitch();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) glitch();
         else press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
         if (ref_won) do_reset();
         repeat ($urandom_range(0, 3)) step();
      end
      do_reset();
      repeat (4) press(1'b0, 1'b0);
      check("left_win", bus.win_l, 1);
      bus.push  = 1'b1;
      bus.right = 1'b1;
      repeat (12) step();
      bus.push  = 1'b0;
      bus.right = 1'b0;
      check("win_moves", bus.moves, 4);
      check("win_hold", {bus.win_l, bus.win_r, bus.clear}, 3'b101);
      do_reset();
      repeat (4) press(1'b1, 1'b0);
      check("right_win", bus.win_r, 1);
      do_reset();
      bus.push  = 1'b1;
      bus.right = 1'b1;
      for (int n = 0; n < 20 && !bus.clear; n++) step();
      bus.push  = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.right = 1'b0;
      check("midlock_clear", bus.clear, 0);
      check("midlock_leds", bus.leds, 32'h10);
      check("midlock_moves", bus.moves, 0);
      ref_pos   = 4;
      ref_moves = 0;
      ref_won   = 1'b0;
      repeat (3) step();
      for (int i = 0; i < 256; i++) press(i % 2 == 0, 1'b0);
      check("sat_moves", bus.moves, 255);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rope_ctrl.md
ROPE_CTRL -- requirements
Module: rope_ctrl

Interface
REQ-001 SHALL have parameter LOCKOUT, default 4, number of cycles clear is held after each decided push; legal range 3..255.
REQ-002 SHALL have parameter BLINK, default 8, half-period in cycles of the winner LED blink; legal range 1..255.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 push input 1: a player's press has been latched upstream; asynchronous to clk.
REQ-005 tie input 1: both presses were latched simultaneously upstream; asynchronous to clk.
REQ-006 right input 1: only the right player's press was latched; asynchronous to clk.
REQ-007 clear output 1: registered; re-arms the upstream press latches.
REQ-008 leds output 9: registered one-hot rope position; bit 0 is the left end, bit 8 the right end.
REQ-009 win_l output 1: registered; the left player has won.
REQ-010 win_r output 1: registered; the right player has won.
REQ-011 moves output 8: registered count of non-tie moves; saturates at 255.

Function
REQ-012 push, tie and right SHALL each pass through a 2-flop synchronizer; the suffix _s below denotes the synchronized value.
REQ-013 Position pos SHALL be 4 bits in the range 0..8; leds SHALL equal 1<<pos outside WIN.
REQ-014 The FSM SHALL have exactly the states IDLE, SETTLE, MOVE, LOCK and WIN.
REQ-015 IDLE: clear=0; push_s=1 -> SETTLE; otherwise stay.
REQ-016 SETTLE: push_s=1 -> MOVE and capture tie_s and right_s; push_s=0 (glitch) -> IDLE with no move.
REQ-017 MOVE lasts one cycle: tie -> pos unchanged and moves unchanged; right=1 -> pos+1 and moves+1; right=0 -> pos-1 and moves+1.
REQ-018 From MOVE: updated pos==0 -> WIN with win_l=1; updated pos==8 -> WIN with win_r=1; otherwise -> LOCK.
REQ-019 LOCK: clear=1 for exactly LOCKOUT consecutive cycles (counted by an 8-bit counter), then -> IDLE with clear=0.
REQ-020 Press latency SHALL be push rising at the input -> clear first high in 5 cycles (2 sync + SETTLE + MOVE + registered output).
REQ-021 A push still asserted on the first IDLE cycle after LOCK (button held) SHALL be treated as a new press.
REQ-022 WIN SHALL be terminal until rst.
REQ-023 In WIN: clear=1 continuously; push, tie and right ignored; the winning win_x held at 1; moves frozen.
REQ-024 In WIN: leds SHALL toggle between 1<<pos and 0 every BLINK cycles, starting lit on WIN entry.
REQ-025 The moves counter SHALL hold at 255 and never wrap.
REQ-026 The tie input SHALL take priority over right if both are captured high.
REQ-027 Nothing SHALL be decided combinationally from the unsynchronized inputs.

Reset
REQ-028 rst=1 at a clock edge SHALL, in any state including mid-LOCK or WIN, force: state=IDLE, pos=4, leds=9'b000010000, clear=0, win_l=0, win_r=0, moves=0, lockout counter=0, blink counter=0, sync flops=0.
REQ-029 rst SHALL take priority over every other input.
REQ-030 Outputs SHALL take their reset values on the first clock after rst rises.

Verification
REQ-031 Single press: push=1, right=1 held until clear -> leds 9'b000100000, moves=1, clear high for exactly 4 cycles, then IDLE.
REQ-032 Tie: push=1, tie=1, right=0 -> leds stays 9'b000010000, moves=0, clear pulse of 4 cycles.
REQ-033 Glitch: push high for 1 cycle only (dropped before SETTLE samples it) -> no clear and no move.
REQ-034 Left win: 4 left presses (push=1, right=0) -> pos=0, win_l=1, clear stuck at 1, leds toggling bit0/0 every 8 cycles, further pushes ignored.
REQ-035 Reset mid-LOCK: rst asserted on the 2nd LOCK cycle -> next cycle clear=0, leds=9'b000010000, moves=0.
REQ-036 Saturation: 255 alternating right/left moves, then one more move -> moves holds at 255.
